// File: rtl/md_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
// ALU opcodes match the ALU decoder encoding.
package md_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        OP_MUL  = 3'b000,
        OP_DIV  = 3'b100,
        OP_DIVU = 3'b101,
        OP_REM  = 3'b110,
        OP_REMU = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEGA,
        S_NEGB,
        S_ITER,
        S_NEGR,
        S_DONE
    } md_state_t;

endpackage

// File: rtl/md_if.sv
// Core-side request/response bundle plus the borrowed ALU port.
// master = execute stage / ALU owner, slave = md_seq.
interface md_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     start;
    logic [2:0]               op;
    logic [DATA_WIDTH-1:0]    a;
    logic [DATA_WIDTH-1:0]    b;
    logic                     kill;
    logic                     ready;
    logic                     done;
    logic [DATA_WIDTH-1:0]    result;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    alu_srca;
    logic [DATA_WIDTH-1:0]    alu_srcb;
    logic [DATA_WIDTH-1:0]    alu_result;

    modport master (
        output start, op, a, b, kill, alu_result,
        input  ready, done, result, alu_op, alu_srca, alu_srcb
    );

    modport slave (
        input  start, op, a, b, kill, alu_result,
        output ready, done, result, alu_op, alu_srca, alu_srcb
    );
endinterface

// File: rtl/md_seq.sv
// RV32M multiply/divide sequencer: shift-add MUL and restoring DIV/REM,
// with every add/sub/negate routed through the shared ALU.
module md_seq
    import md_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input logic clk,
    input logic rst_n,
    md_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};
    localparam logic [OPCODE_LENGTH-1:0] OPC_ADD = OPCODE_LENGTH'(ALU_ADD);
    localparam logic [OPCODE_LENGTH-1:0] OPC_SUB = OPCODE_LENGTH'(ALU_SUB);

    md_state_t     state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nega_q, nega_d;
    logic          negb_q, negb_d;
    logic [W-1:0]  result_q, result_d;

    logic          in_div, in_sgn, in_rem, in_ok;
    logic          q_mul, q_div_s, q_rem_s, q_rem;
    logic          cout, take, negr;
    logic [W-1:0]  rem_sh;

    assign in_div = bus.op[2];
    assign in_ok  = (bus.op == OP_MUL) || in_div;
    assign in_sgn = (bus.op == OP_DIV) || (bus.op == OP_REM);
    assign in_rem = bus.op[1];

    assign q_mul   = (op_q == OP_MUL);
    assign q_div_s = (op_q == OP_DIV);
    assign q_rem_s = (op_q == OP_REM);
    assign q_rem   = op_q[2] & op_q[1];

    // acc holds the partial remainder; opa shifts dividend out, quotient in
    assign cout   = acc_q[W-1];
    assign rem_sh = {acc_q[W-2:0], opa_q[W-1]};
    assign take   = cout | (rem_sh >= opb_q);

    assign bus.ready  = (state_q == S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        acc_d        = acc_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        cnt_d        = cnt_q;
        nega_d       = nega_q;
        negb_d       = negb_q;
        result_d     = result_q;
        negr         = 1'b0;
        bus.alu_op   = OPC_ADD;
        bus.alu_srca = '0;
        bus.alu_srcb = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.kill) begin
                    op_d   = bus.op;
                    opa_d  = bus.a;
                    opb_d  = bus.b;
                    acc_d  = '0;
                    cnt_d  = CW'(W - 1);
                    nega_d = in_sgn & bus.a[W-1];
                    negb_d = in_sgn & bus.b[W-1];
                    if (!in_ok) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else if (in_div && bus.b == '0) begin
                        result_d = in_rem ? bus.a : '1;
                        state_d  = S_DONE;
                    end else if (in_sgn && bus.a == MIN_INT
                                 && bus.b == '1) begin
                        result_d = in_rem ? '0 : MIN_INT;
                        state_d  = S_DONE;
                    end else if (nega_d) begin
                        state_d = S_NEGA;
                    end else if (negb_d) begin
                        state_d = S_NEGB;
                    end else begin
                        state_d = S_ITER;
                    end
                end
            end
            S_NEGA: begin
                bus.alu_op   = OPC_SUB;
                bus.alu_srcb = opa_q;
                opa_d        = bus.alu_result;
                state_d      = negb_q ? S_NEGB : S_ITER;
            end
            S_NEGB: begin
                bus.alu_op   = OPC_SUB;
                bus.alu_srcb = opb_q;
                opb_d        = bus.alu_result;
                state_d      = S_ITER;
            end
            S_ITER: begin
                cnt_d = cnt_q - 1'b1;
                if (q_mul) begin
                    bus.alu_srca = acc_q;
                    bus.alu_srcb = opa_q;
                    if (opb_q[0]) acc_d = bus.alu_result;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    bus.alu_op   = OPC_SUB;
                    bus.alu_srca = rem_sh;
                    bus.alu_srcb = opb_q;
                    acc_d = take ? bus.alu_result : rem_sh;
                    opa_d = {opa_q[W-2:0], take};
                end
                if (cnt_q == '0) begin
                    negr = (q_div_s && (nega_q ^ negb_q) && opa_d != '0)
                        || (q_rem_s && nega_q && acc_d != '0);
                    if (negr) begin
                        state_d = S_NEGR;
                    end else begin
                        result_d = (q_mul || q_rem) ? acc_d : opa_d;
                        state_d  = S_DONE;
                    end
                end
            end
            S_NEGR: begin
                bus.alu_op   = OPC_SUB;
                bus.alu_srcb = q_rem ? acc_q : opa_q;
                result_d     = bus.alu_result;
                state_d      = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush drops the operation without touching the visible result
        if (bus.kill && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            nega_q   <= 1'b0;
            negb_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            nega_q   <= nega_d;
            negb_q   <= negb_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// Bench for md_seq: vector table, reference-model random ops and
// hand-written abort/reset sequences, checked through a scoreboard queue.
module tb_md_seq;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    md_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

    md_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Shared single-cycle ALU stand-in
    always_comb begin
        bus.alu_result = '0;
        if (bus.alu_op == ALU_ADD)
            bus.alu_result = bus.alu_srca + bus.alu_srcb;
        else if (bus.alu_op == ALU_SUB)
            bus.alu_result = bus.alu_srca - bus.alu_srcb;
    end

    typedef struct {
        logic [31:0] res;
        int          n;
    } exp_t;

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          n;
    } vec_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_res(logic [2:0] op,
                                            logic [31:0] a,
                                            logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b000: return a * b;
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            3'b111: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_n(logic [2:0] op, logic [31:0] a,
                                 logic [31:0] b);
        int n;
        logic [31:0] r;
        if (op != 3'b000 && !op[2]) return 1;
        if (op[2] && b == 0) return 1;
        if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000
            && b == 32'hFFFF_FFFF) return 1;
        n = 33;
        r = ref_res(op, a, b);
        if (op == 3'b100 || op == 3'b110) begin
            n += int'(a[31]) + int'(b[31]);
            if (op == 3'b100 && (a[31] != b[31]) && r != 0) n++;
            if (op == 3'b110 && a[31] && r != 0) n++;
        end
        return n;
    endfunction

    task automatic issue(string nm, logic [2:0] op, logic [31:0] a,
                         logic [31:0] b);
        @(negedge clk);
        chk({nm, "_ready"}, 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic await_done(string nm, logic [2:0] op, int pre);
        exp_t e;
        int   edges;
        bit   seen;
        bit   badalu;
        edges  = pre;
        seen   = 1'b0;
        badalu = 1'b0;
        while (!seen && edges < 60) begin
            @(negedge clk);
            edges++;
            if (op == 3'b000 && bus.alu_op != ALU_ADD) badalu = 1'b1;
            if (bus.done) seen = 1'b1;
        end
        e = sbq.pop_front();
        if (!seen) begin
            total++;
            $display("FAIL %s_timeout: no done in %0d cycles, expected at %0d",
                     nm, edges, e.n);
        end else begin
            chk({nm, "_res"}, bus.result, e.res);
            chk({nm, "_lat"}, 32'(edges), 32'(e.n));
        end
        if (op == 3'b000) chk({nm, "_aluop"}, 32'(badalu), 32'd0);
    endtask

    task automatic run_op(string nm, logic [2:0] op, logic [31:0] a,
                          logic [31:0] b, logic [31:0] res, int n);
        issue(nm, op, a, b);
        sbq.push_back('{res: res, n: n});
        await_done(nm, op, 0);
    endtask

    task automatic no_done(string nm, int cycles);
        int cnt;
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk(nm, 32'(cnt), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [2:0]  ops[5];

        vecs = '{
            '{"mul_neg",   3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
            '{"divu",      3'b101, 32'd100,      32'd7,         32'd14,        33},
            '{"remu",      3'b111, 32'd100,      32'd7,         32'd2,         33},
            '{"div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{"rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1},
            '{"div_nega",  3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35},
            '{"rem_nega",  3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35},
            '{"div_negb",  3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 35},
            '{"div_z",     3'b100, 32'd5,        32'd0,         32'hFFFF_FFFF, 1},
            '{"rem_z",     3'b110, 32'd5,        32'd0,         32'd5,         1},
            '{"divu_z",    3'b101, 32'd5,        32'd0,         32'hFFFF_FFFF, 1},
            '{"unsup",     3'b001, 32'd5,        32'd3,         32'd0,         1},
            '{"divu_cout", 3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,        33},
            '{"remu_cout", 3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33}
        };
        ops = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};

        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.kill  = 1'b0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_aluop", 32'(bus.alu_op), 32'(ALU_ADD));
        chk("rst_srca", bus.alu_srca, 32'd0);
        chk("rst_srcb", bus.alu_srcb, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].n);

        for (int i = 0; i < 8; i++) begin
            rop = ops[$urandom_range(0, 4)];
            ra  = $urandom;
            rb  = $urandom;
            if (i == 3) rb = rb >> 20;
            run_op($sformatf("rand%0d", i), rop, ra, rb,
                   ref_res(rop, ra, rb), ref_n(rop, ra, rb));
        end

        // Start during ITER must be ignored
        issue("busy", 3'b101, 32'd100, 32'd7);
        sbq.push_back('{res: 32'd14, n: 33});
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        await_done("busy", 3'b101, 6);
        no_done("busy_extra_done", 40);

        // Kill at ITER cycle 10
        issue("kill", 3'b000, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        chk("kill_ready", 32'(bus.ready), 32'd1);
        chk("kill_done", 32'(bus.done), 32'd0);
        no_done("kill_no_done", 40);
        chk("kill_result", bus.result, 32'd14);

        // Kill with start in IDLE
        @(negedge clk);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        bus.op    = 3'b101;
        bus.a     = 32'd9;
        bus.b     = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        chk("killstart_ready", 32'(bus.ready), 32'd1);
        no_done("killstart_no_done", 40);

        // Reset mid-ITER
        issue("rstmid", 3'b101, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", 32'(bus.ready), 32'd1);
        chk("rstmid_done", 32'(bus.done), 32'd0);
        chk("rstmid_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_done("rstmid_no_done", 40);

        // Back-to-back: second accept lands on the cycle after done
        run_op("b2b_a", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("b2b_b", 3'b000, 32'd6, 32'd7, 32'd42, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
